// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory as big-endian 32-bit words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
  parameter logic [9:0]  BASE_ADDR = 10'h000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        WrEn,
  output logic [9:0]  WrAddr,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        CpuStall,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLen0 = 3'd1,
    StLen1 = 3'd2,
    StData = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StChk  = 3'd4,
`endif
    StFin  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [15:0] len_in;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  assign len_in = {ByteIn, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A byte arriving with Start is dropped; the length starts at the next valid byte.
        if (Start) begin
          state_d    = StLen0;
          error_d    = 1'b0;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
        end
      end
      StLen0: begin
        if (ByteValid) begin
          len_lo_d = ByteIn;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (ByteValid) begin
          len_d = len_in;
          if (len_in == 16'd0 || 32'(len_in) > MAX_WORDS) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (ByteValid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = {asm_q[15:0], ByteIn};
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ ByteIn;
`endif
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {asm_q, ByteIn};
            wr_addr_d  = BASE_ADDR + word_cnt_q[9:0];
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StFin;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (ByteValid) begin
          if (ByteIn == xor_q) begin
            state_d = StFin;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q    <= StIdle;
      len_lo_q   <= 8'h00;
      len_q      <= 16'h0000;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'h0000;
      asm_q      <= 24'h000000;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 10'h000;
      wr_data_q  <= 32'h00000000;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      error_q    <= error_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      xor_q <= 8'h00;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  assign WrEn     = wr_en_q;
  assign WrAddr   = wr_addr_q;
  assign WrData   = wr_data_q;
  assign Busy     = (state_q != StIdle);
  assign CpuStall = Busy;
  assign Done     = (state_q == StFin);
  assign Error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0x000 and 0x3FF) fed the same stream,
// checked against a byte-list reference model.
module tb_imem_loader;

  localparam int unsigned MaxWords = 1024;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;

  logic        wr_en0, busy0, stall0, done0, err0;
  logic [9:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        wr_en1, busy1, stall1, done1, err1;
  logic [9:0]  wr_addr1;
  logic [31:0] wr_data1;

  imem_loader #(.BASE_ADDR(10'h000), .MAX_WORDS(MaxWords)) u_dut0 (
    .Clk(Clk), .Clr(Clr), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .WrEn(wr_en0), .WrAddr(wr_addr0), .WrData(wr_data0), .Busy(busy0),
    .CpuStall(stall0), .Done(done0), .Error(err0)
  );

  imem_loader #(.BASE_ADDR(10'h3FF), .MAX_WORDS(MaxWords)) u_dut1 (
    .Clk(Clk), .Clr(Clr), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .WrEn(wr_en1), .WrAddr(wr_addr1), .WrData(wr_data1), .Busy(busy1),
    .CpuStall(stall1), .Done(done1), .Error(err1)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        obs0[$], obs1[$], exp0[$], exp1[$];
  int         done_cyc0 = 0;
  int         done_cyc1 = 0;
  logic [7:0] stim[$];
  wr_t        last0 = '0;
  wr_t        last1 = '0;

  // Write and Done monitor; sampled on the falling edge.
  always @(negedge Clk) begin
    if (!Clr) begin
      if (wr_en0) obs0.push_back('{addr: wr_addr0, data: wr_data0});
      if (wr_en1) obs1.push_back('{addr: wr_addr1, data: wr_data1});
      if (done0) done_cyc0 <= done_cyc0 + 1;
      if (done1) done_cyc1 <= done_cyc1 + 1;
    end
  end

  task automatic cyc(input logic s, input logic v, input logic [7:0] b);
    Start     = s;
    ByteValid = v;
    ByteIn    = b;
    @(posedge Clk);
    #1;
    Start     = 1'b0;
    ByteValid = 1'b0;
    ByteIn    = 8'($urandom);
  endtask

  // Expected writes and outcome straight from the byte list.
  task automatic model(output bit ok);
    int n;
    logic [7:0] x;
    exp0.delete();
    exp1.delete();
    ok = 1'b0;
    n  = int'({stim[1], stim[0]});
    if (n == 0 || n > int'(MaxWords)) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp0.push_back('{addr: 10'(i % 1024), data: w});
      exp1.push_back('{addr: 10'((1023 + i) % 1024), data: w});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = (stim[2+4*n] == x);
`else
    ok = 1'b1;
`endif
  endtask

  task automatic make_load(input int n, input bit bad_sum);
    logic [7:0] x;
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      x = x ^ b;
      stim.push_back(b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(bad_sum ? ~x : x);
`else
    if (bad_sum) x = ~x;
`endif
  endtask

  task automatic run_load(input int max_gap, input bit junk, input bit restart, input int long_at);
    bit ok;
    bit valid_len;
    int len_n, o0, o1, d0, d1, t;
    model(ok);
    len_n     = int'({stim[1], stim[0]});
    valid_len = (len_n != 0) && (len_n <= int'(MaxWords));
    o0 = obs0.size();
    o1 = obs1.size();
    d0 = done_cyc0;
    d1 = done_cyc1;
    cyc(1'b1, junk, 8'($urandom));
    check("start_err", 32'(err0), 32'd0);
    check("start_busy", 32'(busy0), 32'd1);
    check("start_stall", 32'(stall1), 32'd1);
    for (int i = 0; i < stim.size(); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      if (i == long_at) gap = 50;
      for (int g = 0; g < gap; g++)
        cyc(restart && valid_len && i >= 2 && g == 0, 1'b0, 8'($urandom));
      cyc(1'b0, 1'b1, stim[i]);
      if (i == 1 && !valid_len) begin
        check("len_err", 32'(err0), 32'd1);
        check("len_busy", 32'(busy0), 32'd0);
      end
    end
    if (valid_len) begin
      check("end_busy0", 32'(busy0), 32'(ok));
      check("end_done0", 32'(done0), 32'(ok));
      check("end_done1", 32'(done1), 32'(ok));
    end
    t = 0;
    while ((busy0 || busy1) && t < 10) begin
      cyc(1'b0, 1'b0, 8'($urandom));
      t++;
    end
    cyc(1'b0, 1'b0, 8'($urandom));
    check("idle_busy0", 32'(busy0), 32'd0);
    check("idle_stall1", 32'(stall1), 32'd0);
    check("err0", 32'(err0), 32'(!ok));
    check("err1", 32'(err1), 32'(!ok));
    check("done_cnt0", 32'(done_cyc0 - d0), 32'(ok));
    check("done_cnt1", 32'(done_cyc1 - d1), 32'(ok));
    check("nwr0", 32'(obs0.size() - o0), 32'(exp0.size()));
    check("nwr1", 32'(obs1.size() - o1), 32'(exp1.size()));
    for (int i = 0; i < exp0.size() && o0 + i < obs0.size(); i++) begin
      check("addr0", 32'(obs0[o0+i].addr), 32'(exp0[i].addr));
      check("data0", obs0[o0+i].data, exp0[i].data);
    end
    for (int i = 0; i < exp1.size() && o1 + i < obs1.size(); i++) begin
      check("addr1", 32'(obs1[o1+i].addr), 32'(exp1[i].addr));
      check("data1", obs1[o1+i].data, exp1[i].data);
    end
    if (exp0.size() > 0) begin
      last0 = exp0[exp0.size()-1];
      last1 = exp1[exp1.size()-1];
    end
    check("hold_addr0", 32'(wr_addr0), 32'(last0.addr));
    check("hold_data0", wr_data0, last0.data);
    check("hold_addr1", 32'(wr_addr1), 32'(last1.addr));
    check("hold_data1", wr_data1, last1.data);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, 32'({wr_en0, wr_en1}), 32'd0);
    check({tag, "_addr0"}, 32'(wr_addr0), 32'd0);
    check({tag, "_addr1"}, 32'(wr_addr1), 32'd0);
    check({tag, "_data0"}, wr_data0, 32'd0);
    check({tag, "_data1"}, wr_data1, 32'd0);
    check({tag, "_busy"}, 32'({busy0, busy1, stall0, stall1}), 32'd0);
    check({tag, "_done"}, 32'({done0, done1}), 32'd0);
    check({tag, "_err"}, 32'({err0, err1}), 32'd0);
  endtask

  task automatic abort_test(input int nbytes);
    bit ok;
    int o0, d0, nw;
    make_load(2, 1'b0);
    model(ok);
    o0 = obs0.size();
    d0 = done_cyc0;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2 + nbytes; i++) cyc(1'b0, 1'b1, stim[i]);
    cyc(1'b0, 1'b0, 8'h00);
    #2 Clr = 1'b1;
    #1 check_zero("abort");
    @(negedge Clk);
    @(posedge Clk);
    #1 Clr = 1'b0;
    last0 = '0;
    last1 = '0;
    cyc(1'b0, 1'b0, 8'h00);
    nw = nbytes / 4;
    check("abort_nwr", 32'(obs0.size() - o0), 32'(nw));
    if (nw > 0 && obs0.size() > o0) check("abort_data", obs0[o0].data, exp0[0].data);
    check("abort_done", 32'(done_cyc0 - d0), 32'd0);
    check_zero("abort_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Clr = 1'b1;
    Start = 1'b0;
    ByteValid = 1'b0;
    ByteIn = 8'h00;
    repeat (3) @(posedge Clk);
    #1 check_zero("reset");
    Clr = 1'b0;
    cyc(1'b0, 1'b1, 8'h5A);
    check_zero("post_reset");

    // Two-word reference image.
    stim = '{8'h02, 8'h00, 8'h24, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h24 ^ 8'h01 ^ 8'h05 ^ 8'hAC ^ 8'h01);
`endif
    run_load(0, 1'b0, 1'b0, -1);
    if (obs0.size() >= 2) begin
      check("ref_w0", obs0[obs0.size()-2].data, 32'h24010005);
      check("ref_w1", obs0[obs0.size()-1].data, 32'hAC010000);
      check("ref_a1", 32'(obs0[obs0.size()-1].addr), 32'd1);
    end

    // Zero length, then sticky Error.
    stim = '{8'h00, 8'h00};
    run_load(0, 1'b0, 1'b0, -1);
    repeat (5) cyc(1'b0, 1'b1, 8'h33);
    check("sticky_err", 32'(err0), 32'd1);

    // Oversize length followed by bytes the idle loader must ignore.
    stim = '{8'h01, 8'h04, 8'hAA, 8'h55, 8'h12};
    run_load(2, 1'b1, 1'b0, -1);

    // Restarts and a 50-cycle stall inside word 0.
    make_load(2, 1'b0);
    run_load(0, 1'b1, 1'b1, 4);

    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h44);
    run_load(1, 1'b0, 1'b0, -1);
    stim[6] = 8'h45;
`endif
    run_load(1, 1'b0, 1'b0, -1);

    abort_test(2);
    abort_test(6);

    // Largest accepted image.
    make_load(int'(MaxWords), 1'b0);
    run_load(0, 1'b0, 1'b0, -1);

    for (int k = 0; k < 25; k++) begin
      make_load(int'($urandom_range(6, 1)), $urandom_range(3) == 0);
      run_load(3, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 10'h000, which is the first instruction-memory word address written.
REQ-002 The module SHALL have parameter MAX_WORDS, default 1024, which is the largest accepted word count.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port Clr, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port Start, input, 1 bit: a load-request pulse.
REQ-006 The module SHALL have port ByteIn, input, 8 bits: the incoming program byte.
REQ-007 The module SHALL have port ByteValid, input, 1 bit: ByteIn is valid in this cycle, one byte per asserted cycle.
REQ-008 The module SHALL have port WrEn, output, 1 bit: the instruction-memory write strobe.
REQ-009 The module SHALL have port WrAddr, output, 10 bits: the instruction-memory word address.
REQ-010 The module SHALL have port WrData, output, 32 bits: the instruction word.
REQ-011 The module SHALL have port Busy, output, 1 bit: a load is in progress.
REQ-012 The module SHALL have port CpuStall, output, 1 bit: holds the fetch unit while a load is in progress.
REQ-013 The module SHALL have port Done, output, 1 bit: a one-cycle pulse on successful completion.
REQ-014 The module SHALL have port Error, output, 1 bit: a sticky load-failure flag.

Function
REQ-015 The module SHALL implement FSM states IDLE, LEN0, LEN1, DATA, CHK, FIN.
REQ-016 In IDLE, Start=1 SHALL go to LEN0, clear Error, and set the byte counter and word counter to 0; ByteValid SHALL be ignored in IDLE.
REQ-017 LEN0/LEN1 SHALL capture the low and then the high byte of a 16-bit word count N, one state per valid byte.
REQ-018 In LEN1, if N==0 or N>MAX_WORDS on the accepting byte, the FSM SHALL set Error=1 and return to IDLE with no writes and no Done.
REQ-019 In DATA, each valid byte SHALL shift into a 32-bit assembly register big-endian (first byte -> WrData[31:24]).
REQ-020 On the 4th byte of a word, WrEn SHALL be 1 for exactly the next cycle, with WrData equal to the assembled word and WrAddr equal to (BASE_ADDR + word index) mod 1024.
REQ-021 WrAddr SHALL wrap from 10'h3FF to 10'h000 without error.
REQ-022 After word N-1 is written, the FSM SHALL go to CHK if REQ-032 is enabled, else to FIN.
REQ-023 FIN SHALL assert Done for one cycle and return to IDLE next cycle.
REQ-024 Busy and CpuStall SHALL be 1 in every state except IDLE, and CpuStall SHALL equal Busy combinationally.
REQ-025 Start while Busy=1 SHALL be ignored.
REQ-026 Start and ByteValid in the same IDLE cycle SHALL cause that byte to be discarded; the first length byte is the next valid byte.
REQ-027 Gaps of any length between valid bytes SHALL be allowed, with no timeout.
REQ-028 WrData and WrAddr SHALL hold their last values when WrEn=0.

Reset
REQ-029 Clr=1 SHALL asynchronously force state IDLE and WrEn=0, WrAddr=0, WrData=0, Busy=0, CpuStall=0, Done=0, Error=0, and clear all counters.
REQ-030 Clr asserted mid-load SHALL abort the load; words already written SHALL remain written, with no Done and no Error.
REQ-031 After Clr is released, the first rising edge SHALL see the FSM in IDLE.

Configuration
REQ-032 When IMEM_LOADER_CHECKSUM_EN is defined, the FSM SHALL enter CHK after the last word and take one further valid byte; if that byte equals the XOR of all data bytes the FSM SHALL go to FIN, otherwise it SHALL set Error=1 and return to IDLE with no Done.
REQ-033 When IMEM_LOADER_CHECKSUM_EN is undefined, CHK and the XOR accumulator SHALL be absent, DATA SHALL go directly to FIN, and Error SHALL be set only by REQ-018.

Verification
REQ-034 Scenario: BASE_ADDR=0, Start, then bytes 02 00 24 01 00 05 AC 01 00 00 -> WrEn pulses twice with WrAddr 0 and 1 and WrData 0x24010005 and 0xAC010000, then Done=1 for one cycle, Busy=0, and Error=0.
REQ-035 Scenario: Start, then bytes 00 00 -> Error=1, no WrEn, Busy falls after the second byte.
REQ-036 Scenario: BASE_ADDR=0x3FF, N=2 -> writes land at 0x3FF then 0x000.
REQ-037 Scenario: Clr pulsed after the 2nd data byte of word 0 -> all outputs are 0 immediately, with no WrEn and no Done.
REQ-038 Scenario: with IMEM_LOADER_CHECKSUM_EN, N=1, data 11 22 33 44, trailing byte 44 -> Done; same data with trailing byte 45 -> Error=1, no Done.
REQ-039 Scenario: Start re-pulsed during DATA and ByteValid held low for 50 cycles mid-word -> the load completes unchanged.
